// File: rtl/codif_pkg.sv
// Shared types and constants for the 4->2 pending priority encoder.
// The optional lost-event counter is enabled with CODIF_CONT_PERDA_EN.
package codif_pkg;

  typedef enum logic {
    OCIOSO = 1'b0,
    VALIDO = 1'b1
  } estado_t;

  localparam logic [1:0] IDX0 = 2'd0;
  localparam logic [1:0] IDX1 = 2'd1;
  localparam logic [1:0] IDX2 = 2'd2;
  localparam logic [1:0] IDX3 = 2'd3;

  localparam int CONT_W = 8;

endpackage

// File: rtl/sinc_borda.sv
// One request line: SYNC_STAGES-deep synchronizer followed by a rising-edge detector.
module sinc_borda #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic e
);

  logic ds;
  logic prev;

  generate
    if (SYNC_STAGES == 0) begin : g_direto
      assign ds = d;
    end else begin : g_sinc
      logic [SYNC_STAGES-1:0] sync;

      // NOTE: sequential state uses <= so every stage samples the pre-edge value
      // of its neighbour; blocking = here would collapse the chain into one flop.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync <= '0;
        end else begin
          sync[0] <= d;
          for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
        end
      end

      assign ds = sync[SYNC_STAGES-1];
    end
  endgenerate

  // prev clears on reset, so a line held high through reset gives one event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= ds;
  end

  assign e = ds & ~prev;

endmodule

// File: rtl/codificador_4_2_pend.sv
// Sequential 4->2 priority encoder with pending register and valid/ready output.
// Define CODIF_CONT_PERDA_EN to add the saturating PERDA_CNT lost-event counter.
module codificador_4_2_pend
  import codif_pkg::*;
#(
  parameter bit PRIO_MSB    = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic R,
`ifdef CODIF_CONT_PERDA_EN
  output logic [CONT_W-1:0] PERDA_CNT,
`endif
  output logic A,
  output logic B,
  output logic V,
  output logic GS,
  output logic PERDA
);

  logic [3:0] d_in;
  logic [3:0] e;
  logic [3:0] p, p_next, resto, mask_aceite, perdidos;
  logic [1:0] idx, idx_next;
  logic       aceite;
  estado_t    estado, estado_next;

  assign d_in = {D3, D2, D1, D0};

  for (genvar n = 0; n < 4; n++) begin : g_linha
    sinc_borda #(.SYNC_STAGES(SYNC_STAGES)) u_sinc_borda (
      .clk (clk),
      .rst (rst),
      .d   (d_in[n]),
      .e   (e[n])
    );
  end

  function automatic logic [1:0] vencedor(input logic [3:0] req);
    vencedor = IDX0;
    if (PRIO_MSB) begin
      for (int n = 0; n < 4; n++) if (req[n]) vencedor = 2'(n);
    end else begin
      for (int n = 3; n >= 0; n--) if (req[n]) vencedor = 2'(n);
    end
  endfunction

  // The winner is chosen from P as registered; edges of this cycle are not yet visible.
  assign aceite      = (estado == VALIDO) & R;
  assign mask_aceite = aceite ? (4'b0001 << idx) : 4'b0000;
  assign resto       = p & ~mask_aceite;
  assign p_next      = resto | e;
  assign perdidos    = e & resto;

  // NOTE: every output of this block gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    estado_next = estado;
    idx_next    = idx;
    case (estado)
      OCIOSO: begin
        if (p != 4'b0000) begin
          idx_next    = vencedor(p);
          estado_next = VALIDO;
        end
      end
      VALIDO: begin
        if (R) begin
          if (resto != 4'b0000) idx_next = vencedor(resto);
          else                  estado_next = OCIOSO;
        end
      end
      default: estado_next = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado <= OCIOSO;
      idx    <= IDX0;
      p      <= '0;
      GS     <= 1'b0;
      PERDA  <= 1'b0;
    end else begin
      estado <= estado_next;
      idx    <= idx_next;
      p      <= p_next;
      GS     <= |p_next;
      PERDA  <= PERDA | (|perdidos);
    end
  end

  assign V = (estado == VALIDO);
  assign A = idx[1];
  assign B = idx[0];

`ifdef CODIF_CONT_PERDA_EN
  logic [2:0]      n_perdidos;
  logic [CONT_W:0] soma;

  always_comb begin
    n_perdidos = '0;
    for (int n = 0; n < 4; n++) n_perdidos = n_perdidos + {2'b00, perdidos[n]};
  end

  assign soma = {1'b0, PERDA_CNT} + {{(CONT_W-2){1'b0}}, n_perdidos};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           PERDA_CNT <= '0;
    else if (soma[CONT_W]) PERDA_CNT <= '1;
    else               PERDA_CNT <= soma[CONT_W-1:0];
  end
`endif

endmodule

// File: tb/tb_codificador_4_2_pend.sv
// Self-checking bench: two encoder instances (PRIO_MSB=1 and 0) against a behavioural model.
module tb_codificador_4_2_pend;

  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] d0 = 4'b0000, d1 = 4'b0000;
  logic r0 = 1'b0, r1 = 1'b0;
  logic a0, b0, v0, gs0, perda0;
  logic a1, b1, v1, gs1, perda1;
`ifdef CODIF_CONT_PERDA_EN
  logic [7:0] cnt0, cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  codificador_4_2_pend #(.PRIO_MSB(1'b1), .SYNC_STAGES(S)) dut_msb (
    .clk(clk), .rst(rst),
    .D0(d0[0]), .D1(d0[1]), .D2(d0[2]), .D3(d0[3]), .R(r0),
`ifdef CODIF_CONT_PERDA_EN
    .PERDA_CNT(cnt0),
`endif
    .A(a0), .B(b0), .V(v0), .GS(gs0), .PERDA(perda0)
  );

  codificador_4_2_pend #(.PRIO_MSB(1'b0), .SYNC_STAGES(S)) dut_lsb (
    .clk(clk), .rst(rst),
    .D0(d1[0]), .D1(d1[1]), .D2(d1[2]), .D3(d1[3]), .R(r1),
`ifdef CODIF_CONT_PERDA_EN
    .PERDA_CNT(cnt1),
`endif
    .A(a1), .B(b1), .V(v1), .GS(gs1), .PERDA(perda1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: delay line of D samples, set of pending indices, presented index.
  logic [3:0] m_sync [2][S];
  logic [3:0] m_prev [2];
  logic [3:0] m_p    [2];
  int         m_idx  [2];
  bit         m_v    [2];
  bit         m_gs   [2];
  bit         m_perda[2];
  int         m_cnt  [2];

  function automatic int win(input logic [3:0] req, input bit msb);
    for (int k = 0; k < 4; k++) begin
      int n;
      n = msb ? 3 - k : k;
      if (req[n]) return n;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < S; k++) m_sync[i][k] = 4'b0000;
      m_prev[i] = 4'b0000; m_p[i] = 4'b0000; m_idx[i] = 0;
      m_v[i] = 1'b0; m_gs[i] = 1'b0; m_perda[i] = 1'b0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic [3:0] din, input bit rin, input bit msb);
    logic [3:0] ds, ev, rest;
    int lost;
    ds = m_sync[i][S-1];
    ev = ds & ~m_prev[i];
    m_prev[i] = ds;
    for (int k = S - 1; k > 0; k--) m_sync[i][k] = m_sync[i][k-1];
    m_sync[i][0] = din;
    rest = m_p[i];
    if (m_v[i] && rin) rest[m_idx[i]] = 1'b0;
    lost = 0;
    for (int n = 0; n < 4; n++) if (ev[n] && rest[n]) lost++;
    if (!m_v[i]) begin
      if (m_p[i] != 0) begin m_v[i] = 1'b1; m_idx[i] = win(m_p[i], msb); end
    end else if (rin) begin
      if (rest != 0) m_idx[i] = win(rest, msb);
      else           m_v[i] = 1'b0;
    end
    m_p[i] = rest | ev;
    m_gs[i] = (m_p[i] != 0);
    if (lost > 0) m_perda[i] = 1'b1;
    m_cnt[i] = (m_cnt[i] + lost > 255) ? 255 : m_cnt[i] + lost;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      model_step(0, d0, r0, 1'b1);
      model_step(1, d1, r1, 1'b0);
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    check("msb A", a0, 32'(m_idx[0] >> 1));
    check("msb B", b0, 32'(m_idx[0] & 1));
    check("msb V", v0, 32'(m_v[0]));
    check("msb GS", gs0, 32'(m_gs[0]));
    check("msb PERDA", perda0, 32'(m_perda[0]));
    check("lsb A", a1, 32'(m_idx[1] >> 1));
    check("lsb B", b1, 32'(m_idx[1] & 1));
    check("lsb V", v1, 32'(m_v[1]));
    check("lsb GS", gs1, 32'(m_gs[1]));
    check("lsb PERDA", perda1, 32'(m_perda[1]));
`ifdef CODIF_CONT_PERDA_EN
    check("msb PERDA_CNT", cnt0, 32'(m_cnt[0]));
    check("lsb PERDA_CNT", cnt1, 32'(m_cnt[1]));
`endif
  end

  // Transfer log: outputs snapshotted at negedge, R stable since negedge+1.
  logic s_v0, s_v1;
  logic [1:0] s_i0, s_i1;
  int log0[$], log1[$];

  always @(negedge clk) begin
    s_v0 = v0; s_i0 = {a0, b0};
    s_v1 = v1; s_i1 = {a1, b1};
  end

  always @(posedge clk) begin
    if (!rst && s_v0 && r0) log0.push_back(int'(s_i0));
    if (!rst && s_v1 && r1) log1.push_back(int'(s_i1));
  end

  task automatic nxt(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check_log(input string name, input int got[$], input int exp[$]);
    check({name, " length"}, got.size(), exp.size());
    for (int k = 0; k < exp.size() && k < got.size(); k++)
      check($sformatf("%s[%0d]", name, k), got[k], exp[k]);
  endtask

  initial begin
    #1 rst = 1'b1;
    d0 = 4'b1111;
    nxt(3);
    check("reset V", v0, 0); check("reset A", a0, 0); check("reset B", b0, 0);
    check("reset GS", gs0, 0); check("reset PERDA", perda0, 0);
    rst = 1'b0;

    // All four lines high through reset: one event each, delivered 3,2,1,0.
    nxt(3);
    check("latency V before s+2", v0, 0);
    nxt(1);
    check("latency V at s+2", v0, 1);
    check("first index all-high", {a0, b0}, 2'b11);
    r0 = 1'b1;
    nxt(4);
    r0 = 1'b0;
    check("drained V", v0, 0);
    check("drained GS", gs0, 0);
    d0 = 4'b0000;
    nxt(4);

    // Single D1 pulse held while R=0.
    d0 = 4'b0010; nxt(1); d0 = 4'b0000; nxt(4);
    for (int k = 0; k < 10; k++) begin
      check("hold V", v0, 1);
      check("hold index", {a0, b0}, 2'b01);
      nxt(1);
    end
    r0 = 1'b1; nxt(1); r0 = 1'b0;
    check("accept V", v0, 0);
    check("no loss", perda0, 0);
    nxt(3);

    // Accept index 2 on the same edge where its line re-rises: a new event, not a loss.
    d0 = 4'b0100; nxt(1); d0 = 4'b0000; nxt(4);
    check("idx2 presented", {v0, a0, b0}, 3'b110);
    d0 = 4'b0100; nxt(1); d0 = 4'b0000; nxt(1);
    r0 = 1'b1; nxt(1); r0 = 1'b0;
    check("re-rise GS", gs0, 1);
    check("re-rise PERDA", perda0, 0);
    nxt(1);
    check("re-rise repr", {v0, a0, b0}, 3'b110);
    r0 = 1'b1; nxt(1); r0 = 1'b0;
    check("re-rise drained", {v0, gs0}, 2'b00);
    nxt(3);

    // Lost events while index 1 is held.
    d0 = 4'b0010; nxt(1); d0 = 4'b0000; nxt(4);
    d0 = 4'b0010; nxt(1); d0 = 4'b0000; nxt(4);
    check("loss PERDA", perda0, 1);
    check("loss still idx1", {v0, a0, b0}, 3'b101);
`ifdef CODIF_CONT_PERDA_EN
    check("loss count 1", cnt0, 1);
`endif
    for (int k = 0; k < 299; k++) begin
      d0 = 4'b0010; nxt(1); d0 = 4'b0000; nxt(1);
    end
    nxt(4);
`ifdef CODIF_CONT_PERDA_EN
    check("loss count saturated", cnt0, 255);
`endif
    check("loss PERDA sticky", perda0, 1);
    r0 = 1'b1; nxt(1); r0 = 1'b0; nxt(1);
    check("loss drained V", v0, 0);

    // PRIO_MSB=0: D3 and D0 pending, D1 arrives while 0 is presented.
    d1 = 4'b1001; nxt(1); d1 = 4'b0000; nxt(4);
    check("lsb first", {v1, a1, b1}, 3'b100);
    d1 = 4'b0010; nxt(1); d1 = 4'b0000; nxt(4);
    check("lsb no preempt", {v1, a1, b1}, 3'b100);
    r1 = 1'b1; nxt(3); r1 = 1'b0;
    check("lsb drained", {v1, gs1}, 2'b00);

    // Asynchronous reset while presenting index 2 with P=0110.
    d0 = 4'b0110; nxt(1); d0 = 4'b0000; nxt(4);
    check("pre-reset present", {v0, a0, b0, gs0}, 4'b1101);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async V", v0, 0); check("async A", a0, 0); check("async B", b0, 0);
    check("async GS", gs0, 0); check("async PERDA", perda0, 0);
    nxt(2);
    rst = 1'b0;
    nxt(10);
    check("post-reset idle", {v0, gs0}, 2'b00);

    check_log("order msb", log0, '{3, 2, 1, 0, 1, 2, 2, 1});
    check_log("order lsb", log1, '{0, 1, 3});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
